// File: rtl/memoria_dados_param_if.sv
// Request/response bundle for memoria_dados_param: one valid/ready request
// channel (address, write data, byte enables) and one valid/ready response channel.
interface memoria_dados_param_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                    req_valid;
    logic                    req_ready;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic                    req_write;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic [DATA_WIDTH/8-1:0] req_be;
    logic                    resp_valid;
    logic                    resp_ready;
    logic [DATA_WIDTH-1:0]   resp_rdata;
    logic                    resp_err;

    modport master (
        output req_valid, req_addr, req_write, req_wdata, req_be, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_addr, req_write, req_wdata, req_be, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/memoria_dados_param.sv
// Word-addressed data memory with byte enables, range check and optional MEM_STATS_EN counters.
// Latency: resp_valid rises LATENCY clocks after the accepted request; one access outstanding.
// Backpressure: req_ready low outside IDLE; response held until resp_ready, re-accept one clock later.
module memoria_dados_param #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 20,
    parameter int ADDR_WIDTH = 32,
    parameter int LATENCY    = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    memoria_dados_param_if.slave bus
`ifdef MEM_STATS_EN
    ,
    output logic [31:0]          stat_reads,
    output logic [31:0]          stat_writes,
    output logic [31:0]          stat_errors
`endif
);
    localparam int IW   = $clog2(DEPTH);
    localparam int NB   = DATA_WIDTH / 8;
    localparam int CW   = $clog2(LATENCY) + 1;
    localparam int LOAD = (LATENCY > 1) ? LATENCY - 2 : 0;
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state, state_nxt;
    logic [CW-1:0]           cnt;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   merged;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    err_q;
    logic                    accept;
    logic                    req_ok;
    logic                    addr_ok_q;
    logic                    enter_resp;

    assign bus.req_ready  = (state == IDLE) && !reset;
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

    assign accept     = bus.req_valid && bus.req_ready;
    // Full-width compare so high address bits can never alias into the array.
    assign req_ok     = {1'b0, bus.req_addr} < DEPTH_EXT;
    assign addr_ok_q  = {1'b0, addr_q} < DEPTH_EXT;
    assign enter_resp = (state != RESP) && (state_nxt == RESP);

    // Post-write word: feeds both the array write and the write-first bypass.
    always_comb begin
        merged = mem[bus.req_addr[IW-1:0]];
        for (int i = 0; i < NB; i++) begin
            if (bus.req_write && bus.req_be[i]) begin
                merged[8*i +: 8] = bus.req_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (accept && bus.req_write && req_ok) begin
            mem[bus.req_addr[IW-1:0]] <= merged;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (LATENCY == 1) ? RESP : WAIT;
            WAIT: if (cnt == '0) state_nxt = RESP;
            RESP: if (bus.resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            addr_q <= '0;
        end else if (accept) begin
            cnt    <= CW'(LOAD);
            addr_q <= bus.req_addr;
        end else if (state == WAIT && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // With LATENCY=1 the RESP entry edge is the write edge itself, so the
    // merged word is forwarded; otherwise the array already holds it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (enter_resp) begin
            if (LATENCY == 1) begin
                rdata_q <= req_ok ? merged : '0;
                err_q   <= !req_ok;
            end else begin
                rdata_q <= addr_ok_q ? mem[addr_q[IW-1:0]] : '0;
                err_q   <= !addr_ok_q;
            end
        end
    end

`ifdef MEM_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_reads  <= '0;
            stat_writes <= '0;
            stat_errors <= '0;
        end else if (accept) begin
            if (!req_ok) begin
                stat_errors <= stat_errors + 32'd1;
            end else if (bus.req_write) begin
                stat_writes <= stat_writes + 32'd1;
            end else begin
                stat_reads  <= stat_reads + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_memoria_dados_param.sv
// Three memories (LATENCY 1, 4, 3) share one request stream; a per-instance
// monitor checks every response against a queue filled by the stimulus.
module tb_memoria_dados_param;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 20;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          t0;
    } exp_t;

    logic          clock = 1'b0;
    logic [2:0]    rst = 3'b111;
    logic          req_valid = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic          req_write = 1'b0;
    logic [DW-1:0] req_wdata = '0;
    logic [3:0]    req_be = '0;
    logic          resp_ready = 1'b1;

    logic [2:0]    rr, rv, re;
    logic [DW-1:0] rd [3];
`ifdef MEM_STATS_EN
    logic [31:0]   s_rd [3];
    logic [31:0]   s_wr [3];
    logic [31:0]   s_er [3];
`endif

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_rd = 0, m_wr = 0, m_er = 0;
    exp_t q0[$], q1[$], q2[$];
    exp_t mon_e;
    logic [2:0] seen = 3'b000;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 4 : 3);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : u
        memoria_dados_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
        assign bus.req_valid  = req_valid;
        assign bus.req_addr   = req_addr;
        assign bus.req_write  = req_write;
        assign bus.req_wdata  = req_wdata;
        assign bus.req_be     = req_be;
        assign bus.resp_ready = resp_ready;
        assign rr[g] = bus.req_ready;
        assign rv[g] = bus.resp_valid;
        assign re[g] = bus.resp_err;
        assign rd[g] = bus.resp_rdata;

        memoria_dados_param #(
            .DATA_WIDTH(DW),
            .DEPTH     (DEPTH),
            .ADDR_WIDTH(AW),
            .LATENCY   ((g == 0) ? 1 : ((g == 1) ? 4 : 3))
        ) dut (
            .clock      (clock),
            .reset      (rst[g]),
            .bus        (bus)
`ifdef MEM_STATS_EN
            ,
            .stat_reads (s_rd[g]),
            .stat_writes(s_wr[g]),
            .stat_errors(s_er[g])
`endif
        );
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int qsize(input int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t qfront(input int i);
        case (i)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    task automatic qpop(input int i);
        case (i)
            0:       void'(q0.pop_front());
            1:       void'(q1.pop_front());
            default: void'(q2.pop_front());
        endcase
    endtask

    // Monitor: runs 2 time units after each falling edge.
    always @(negedge clock) begin
        #2;
        for (int i = 0; i < 3; i++) begin
            if (rv[i]) begin
                check($sformatf("resp_expected_%0d", i), 32'(qsize(i) > 0), 32'd1);
                if (qsize(i) > 0) begin
                    mon_e = qfront(i);
                    if (!seen[i]) begin
                        seen[i] = 1'b1;
                        check($sformatf("latency_%0d", i), 32'(cyc - mon_e.t0), 32'(lat_of(i)));
                    end
                    check($sformatf("rdata_%0d", i), rd[i], mon_e.rdata);
                    check($sformatf("err_%0d", i), 32'(re[i]), 32'(mon_e.err));
                    check($sformatf("req_rdy_in_resp_%0d", i), 32'(rr[i]), 32'd0);
                    if (resp_ready) begin
                        qpop(i);
                        seen[i] = 1'b0;
                    end
                end
            end else if (qsize(i) > 0 && !rst[i]) begin
                check($sformatf("req_rdy_in_wait_%0d", i), 32'(rr[i]), 32'd0);
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] be, input logic [31:0] exp_rd, input logic exp_err,
                         input int stall, input logic abort2);
        exp_t e;
        int   k;
        check("idle_before_req", {29'd0, rr}, 32'd7);
        e.t0 = cyc;
        e.rdata = exp_rd;
        e.err = exp_err;
        req_valid = 1'b1;
        req_addr = a;
        req_write = w;
        req_wdata = d;
        req_be = be;
        if (stall > 0) resp_ready = 1'b0;
        @(negedge clock);
        req_valid = 1'b0;
        q0.push_back(e);
        q1.push_back(e);
        if (!abort2) q2.push_back(e);
        if (a >= DEPTH) m_er++;
        else if (w) m_wr++;
        else m_rd++;
        if (abort2) begin
            rst[2] = 1'b1;
            #1;
            check("req_rdy_during_reset", 32'(rr[2]), 32'd0);
            check("resp_vld_after_abort", 32'(rv[2]), 32'd0);
            @(negedge clock);
            rst[2] = 1'b0;
        end
        if (stall > 0) begin
            repeat (stall) @(negedge clock);
            resp_ready = 1'b1;
        end
        k = 0;
        while (rr != 3'b111 && k < 60) begin
            @(negedge clock);
            k++;
        end
        check("return_to_idle", {29'd0, rr}, 32'd7);
        check("queues_drained", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        @(negedge clock);
        for (int i = 0; i < 3; i++) check($sformatf("req_rdy_in_reset_%0d", i), 32'(rr[i]), 32'd0);
        @(negedge clock);
        rst = 3'b000;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_req_rdy_%0d", i), 32'(rr[i]), 32'd1);
            check($sformatf("rst_resp_vld_%0d", i), 32'(rv[i]), 32'd0);
            check($sformatf("rst_rdata_%0d", i), rd[i], 32'd0);
            check($sformatf("rst_err_%0d", i), 32'(re[i]), 32'd0);
        end
        @(negedge clock);

        //     addr          w     wdata          be       exp rdata      err  stall abort
        issue(32'd3,        1'b1, 32'hDEADBEEF, 4'hF,    32'hDEADBEEF, 1'b0, 0, 1'b0);
        issue(32'd3,        1'b0, 32'h0,        4'h0,    32'hDEADBEEF, 1'b0, 0, 1'b0);
        issue(32'd5,        1'b1, 32'h11223344, 4'hF,    32'h11223344, 1'b0, 0, 1'b0);
        issue(32'd5,        1'b1, 32'hAABBCCDD, 4'b0101, 32'h11BB33DD, 1'b0, 0, 1'b0);
        issue(32'd5,        1'b0, 32'h0,        4'h0,    32'h11BB33DD, 1'b0, 0, 1'b0);
        issue(32'd0,        1'b1, 32'h0A0B0C0D, 4'hF,    32'h0A0B0C0D, 1'b0, 0, 1'b0);
        issue(32'd0,        1'b0, 32'h0,        4'h0,    32'h0A0B0C0D, 1'b0, 6, 1'b0);
        issue(32'd20,       1'b1, 32'h12345678, 4'hF,    32'h0,        1'b1, 0, 1'b0);
        issue(32'hFFFFFFFF, 1'b0, 32'h0,        4'h0,    32'h0,        1'b1, 0, 1'b0);
        issue(32'h23,       1'b1, 32'h55555555, 4'hF,    32'h0,        1'b1, 0, 1'b0);
        issue(32'd3,        1'b0, 32'h0,        4'h0,    32'hDEADBEEF, 1'b0, 0, 1'b0);
        issue(32'd5,        1'b0, 32'h0,        4'h0,    32'h11BB33DD, 1'b0, 0, 1'b0);
        issue(32'd7,        1'b1, 32'h0000CAFE, 4'hF,    32'h0000CAFE, 1'b0, 0, 1'b1);
        issue(32'd7,        1'b0, 32'h0,        4'h0,    32'h0000CAFE, 1'b0, 0, 1'b0);
        issue(32'd3,        1'b1, 32'hFFFFFFFF, 4'h0,    32'hDEADBEEF, 1'b0, 0, 1'b0);
        issue(32'd3,        1'b0, 32'h0,        4'h0,    32'hDEADBEEF, 1'b0, 0, 1'b0);

`ifdef MEM_STATS_EN
        // Instance 2 was reset mid-run, so only the first two keep full counts.
        for (int i = 0; i < 2; i++) begin
            check($sformatf("stat_reads_%0d", i), s_rd[i], 32'(m_rd));
            check($sformatf("stat_writes_%0d", i), s_wr[i], 32'(m_wr));
            check($sformatf("stat_errors_%0d", i), s_er[i], 32'(m_er));
        end
`endif

        repeat (2) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
